cache_ctrl_burst: RTL and testbench

Parametrised direct-mapped cache controller FSM. It sits between the CPU request interface (Strobe/DRW) and the main-memory strobe interface, and drives the cache datapath selects. It generalises the single-word write-through controller in three ways: configurable memory wait states, multi-word line fill on a read miss, and an optional write-allocate mode. Tag compare (M) and valid (V) come from the datapath; this block only sequences.

---
 rtl/cache_ctrl_pkg.sv | 38 +++
 rtl/cache_ctrl_burst_wait_ctr.sv | 28 ++
 rtl/cache_ctrl_burst.sv | 160 ++++++++++++++++
 tb/tb_cache_ctrl_burst.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared state type, width and latency helpers for cache_ctrl_burst
package cache_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        READ  = 4'd1,
        RMISS = 4'd2,
        RMEM  = 4'd3,
        RFILL = 4'd4,
        RDONE = 4'd5,
        WRITE = 4'd6,
        WSTB  = 4'd7,
        WMEM  = 4'd8,
        WDATA = 4'd9
    } state_t;

    function automatic int word_sel_w(input int line_words);
        return (line_words <= 1) ? 1 : $clog2(line_words);
    endfunction

    // One memory word costs a strobe cycle, the wait, and a fill cycle.
    function automatic int word_cost(input int wait_cycles);
        return 2 + wait_cycles;
    endfunction

    function automatic int read_miss_cycles(input int wait_cycles, input int line_words);
        return line_words * word_cost(wait_cycles) + 1;
    endfunction

    function automatic int write_cycles(input int wait_cycles);
        return 2 + wait_cycles;
    endfunction

    function automatic int write_alloc_cycles(input int wait_cycles, input int line_words);
        return 2 + wait_cycles + line_words * word_cost(wait_cycles);
    endfunction

endpackage

// File: rtl/cache_ctrl_burst_wait_ctr.sv
// rtl/cache_ctrl_burst_wait_ctr.sv - loadable down counter timing memory wait states
module wait_ctr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    // High on the decrement that brings the count to zero.
    assign zero = (count <= WIDTH'(1));

endmodule

// File: rtl/cache_ctrl_burst.sv
// rtl/cache_ctrl_burst.sv - direct-mapped cache controller FSM with wait states and line fill
module cache_ctrl_burst
    import cache_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 4,
    parameter int LINE_WORDS  = 4,
    parameter int WRITE_ALLOC = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                Strobe,
    input  logic                                DRW,
    input  logic                                M,
    input  logic                                V,
    output logic                                DReady,
    output logic                                W,
    output logic                                MStrobe,
    output logic                                MRW,
    output logic                                RSel,
    output logic                                WSel,
    output logic [word_sel_w(LINE_WORDS)-1:0]   WordSel,
    output logic                                Busy
);

    localparam int            KW     = word_sel_w(LINE_WORDS);
    localparam logic [KW-1:0] K_LAST = KW'(LINE_WORDS - 1);
    localparam logic          ALLOC  = (WRITE_ALLOC != 0);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 255) begin : g_bad_wait
        $error("cache_ctrl_burst: WAIT_CYCLES must be in 1..255");
    end
    if (LINE_WORDS < 1 || LINE_WORDS > 16 || (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_bad_line
        $error("cache_ctrl_burst: LINE_WORDS must be a power of 2 in 1..16");
    end
    if (WRITE_ALLOC != 0 && WRITE_ALLOC != 1) begin : g_bad_alloc
        $error("cache_ctrl_burst: WRITE_ALLOC must be 0 or 1");
    end

    state_t        state, state_nx;
    logic [KW-1:0] k, k_nx;
    logic          hit, hit_nx;
    logic          is_wr, is_wr_nx;
    logic          wc_load, wc_dec, wc_zero;

    wait_ctr #(
        .WIDTH(8)
    ) u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (wc_load),
        .dec      (wc_dec),
        .load_val (8'(WAIT_CYCLES)),
        .zero     (wc_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            k     <= '0;
            hit   <= 1'b0;
            is_wr <= 1'b0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            hit   <= hit_nx;
            is_wr <= is_wr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        k_nx     = k;
        hit_nx   = hit;
        is_wr_nx = is_wr;
        wc_load  = 1'b0;
        wc_dec   = 1'b0;
        DReady   = 1'b0;
        W        = 1'b0;
        MStrobe  = 1'b0;
        MRW      = 1'b0;
        RSel     = 1'b0;
        WSel     = 1'b0;
        WordSel  = '0;
        Busy     = (state != IDLE);
        case (state)
            IDLE: begin
                if (Strobe) begin
                    is_wr_nx = DRW;
                    state_nx = DRW ? WRITE : READ;
                end
            end
            READ: begin
                hit_nx = M & V;
                if (M & V) begin
                    DReady   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    k_nx     = '0;
                    state_nx = RMISS;
                end
            end
            RMISS: begin
                MStrobe  = 1'b1;
                WordSel  = k;
                wc_load  = 1'b1;
                state_nx = RMEM;
            end
            RMEM: begin
                WordSel = k;
                wc_dec  = 1'b1;
                if (wc_zero) state_nx = RFILL;
            end
            RFILL: begin
                W       = 1'b1;
                WSel    = 1'b1;
                WordSel = k;
                // A write-allocate fill finishes with the CPU word write, not RDONE.
                if (k == K_LAST) begin
                    state_nx = is_wr ? WDATA : RDONE;
                end else begin
                    k_nx     = k + KW'(1);
                    state_nx = RMISS;
                end
            end
            RDONE: begin
                DReady   = 1'b1;
                state_nx = IDLE;
            end
            WRITE: begin
                hit_nx   = M & V;
                state_nx = WSTB;
            end
            WSTB: begin
                MStrobe  = 1'b1;
                MRW      = 1'b1;
                wc_load  = 1'b1;
                state_nx = WMEM;
            end
            WMEM: begin
                MRW    = 1'b1;
                wc_dec = 1'b1;
                if (wc_zero) begin
                    if (hit || !ALLOC) begin
                        state_nx = WDATA;
                    end else begin
                        k_nx     = '0;
                        state_nx = RMISS;
                    end
                end
            end
            WDATA: begin
                DReady   = 1'b1;
                W        = hit | ALLOC;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl_burst.sv
// tb/tb_cache_ctrl_burst.sv - directed self-checking bench for cache_ctrl_burst
module tb_cache_ctrl_burst;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, drw, m, v;
    logic s0, s1, s2;
    logic dr0, w0, ms0, mrw0, rs0, ws0, busy0;
    logic dr1, w1, ms1, mrw1, rs1, ws1, busy1;
    logic dr2, w2, ms2, mrw2, rs2, ws2, busy2;
    logic [1:0] wsel0, wsel1;
    logic [0:0] wsel2;

    int tests = 0;
    int fails = 0;

    cache_ctrl_burst #(.WAIT_CYCLES(4), .LINE_WORDS(4), .WRITE_ALLOC(0)) u_d0 (
        .clk(clk), .reset(reset), .Strobe(s0), .DRW(drw), .M(m), .V(v),
        .DReady(dr0), .W(w0), .MStrobe(ms0), .MRW(mrw0), .RSel(rs0), .WSel(ws0),
        .WordSel(wsel0), .Busy(busy0)
    );

    cache_ctrl_burst #(.WAIT_CYCLES(4), .LINE_WORDS(4), .WRITE_ALLOC(1)) u_d1 (
        .clk(clk), .reset(reset), .Strobe(s1), .DRW(drw), .M(m), .V(v),
        .DReady(dr1), .W(w1), .MStrobe(ms1), .MRW(mrw1), .RSel(rs1), .WSel(ws1),
        .WordSel(wsel1), .Busy(busy1)
    );

    cache_ctrl_burst #(.WAIT_CYCLES(1), .LINE_WORDS(1), .WRITE_ALLOC(0)) u_d2 (
        .clk(clk), .reset(reset), .Strobe(s2), .DRW(drw), .M(m), .V(v),
        .DReady(dr2), .W(w2), .MStrobe(ms2), .MRW(mrw2), .RSel(rs2), .WSel(ws2),
        .WordSel(wsel2), .Busy(busy2)
    );

    // Called at a negedge; returns at the negedge of cycle 0 (READ/WRITE).
    task automatic launch(input int which, input logic rw, input logic mm, input logic vv);
        drw = rw; m = mm; v = vv;
        case (which)
            0:       s0 = 1'b1;
            1:       s1 = 1'b1;
            default: s2 = 1'b1;
        endcase
        @(posedge clk);
        @(negedge clk);
        s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; s0 = 1'b0; s1 = 1'b0; s2 = 1'b0; drw = 1'b0; m = 1'b0; v = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({dr0, w0, ms0, mrw0, rs0, ws0, wsel0, busy0} !== 9'b0) begin
            fails++; $display("FAIL reset_d0: got %b want 0", {dr0, w0, ms0, mrw0, rs0, ws0, wsel0, busy0});
        end
        tests++;
        if ({dr1, w1, ms1, mrw1, rs1, ws1, wsel1, busy1} !== 9'b0) begin
            fails++; $display("FAIL reset_d1: got %b want 0", {dr1, w1, ms1, mrw1, rs1, ws1, wsel1, busy1});
        end
        tests++;
        if ({dr2, w2, ms2, mrw2, rs2, ws2, wsel2, busy2} !== 8'b0) begin
            fails++; $display("FAIL reset_d2: got %b want 0", {dr2, w2, ms2, mrw2, rs2, ws2, wsel2, busy2});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_hit();
        logic [5:0] pat;
        int dr_n;
        launch(0, 1'b0, 1'b1, 1'b1);
        tests++;
        if (dr0 !== 1'b1 || busy0 !== 1'b1) begin
            fails++; $display("FAIL rd_hit_cycle0: got dready=%b busy=%b want 1 1", dr0, busy0);
        end
        tests++;
        if ({ms0, w0, rs0} !== 3'b000) begin
            fails++; $display("FAIL rd_hit_quiet: got mstrobe,w,rsel=%b want 000", {ms0, w0, rs0});
        end
        @(negedge clk);
        tests++;
        if (busy0 !== 1'b0 || dr0 !== 1'b0) begin
            fails++; $display("FAIL rd_hit_cycle1: got busy=%b dready=%b want 0 0", busy0, dr0);
        end
        // Strobe held high: a new request is accepted every other cycle.
        s0 = 1'b1; drw = 1'b0; m = 1'b1; v = 1'b1;
        pat = '0; dr_n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat[i] = dr0;
            if (ms0 === 1'b1 || w0 === 1'b1) dr_n += 100;
            if (dr0 === 1'b1) dr_n++;
        end
        s0 = 1'b0;
        @(negedge clk);
        tests++;
        if (pat !== 6'b010101 || dr_n != 3) begin
            fails++; $display("FAIL back_to_back: got pattern %b count %0d want 010101 3", pat, dr_n);
        end
    endtask

    task automatic test_read_miss();
        int dr_cyc = -1, dr_n = 0, ms_n = 0, ms_first = -1, mrw_bad = 0, w_n = 0, sel_bad = 0;
        logic busy_after = 1'b1;
        launch(0, 1'b0, 1'b0, 1'b0);
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (ms0 === 1'b1) begin
                ms_n++;
                if (ms_first < 0) ms_first = cyc;
                if (mrw0 !== 1'b0) mrw_bad++;
            end
            if (w0 === 1'b1) begin
                if (ws0 !== 1'b1 || wsel0 !== 2'(w_n)) sel_bad++;
                w_n++;
            end
            if (dr0 === 1'b1) begin
                dr_n++;
                if (dr_cyc < 0) dr_cyc = cyc;
            end
            if (cyc == 26) busy_after = busy0;
            s0 = (cyc == 8 || cyc == 16);
            @(negedge clk);
        end
        s0 = 1'b0;
        tests++;
        if (dr_cyc != 25) begin fails++; $display("FAIL rd_miss_dready_cycle: got %0d want 25", dr_cyc); end
        tests++;
        if (dr_n != 1) begin fails++; $display("FAIL rd_miss_dready_count: got %0d want 1", dr_n); end
        tests++;
        if (ms_n != 4 || ms_first != 1) begin
            fails++; $display("FAIL rd_miss_mstrobe: got %0d pulses first %0d want 4 first 1", ms_n, ms_first);
        end
        tests++;
        if (mrw_bad != 0) begin fails++; $display("FAIL rd_miss_mrw: got %0d bad strobes want 0", mrw_bad); end
        tests++;
        if (w_n != 4 || sel_bad != 0) begin
            fails++; $display("FAIL rd_miss_fill: got %0d fills %0d bad want 4 0", w_n, sel_bad);
        end
        tests++;
        if (busy_after !== 1'b0) begin fails++; $display("FAIL rd_miss_busy_after: got %b want 0", busy_after); end
    endtask

    task automatic test_write_hit();
        for (int h = 1; h >= 0; h--) begin
            int ms_n = 0, ms_cyc = -1, mrw_n = 0, w_n = 0, w_cyc = -1, ws_bad = 0, dr_cyc = -1;
            launch(0, 1'b1, h[0], 1'b1);
            for (int cyc = 0; cyc < 10; cyc++) begin
                if (ms0 === 1'b1) begin ms_n++; ms_cyc = cyc; end
                if (mrw0 === 1'b1) mrw_n++;
                if (w0 === 1'b1) begin w_n++; w_cyc = cyc; if (ws0 !== 1'b0) ws_bad++; end
                if (dr0 === 1'b1 && dr_cyc < 0) dr_cyc = cyc;
                @(negedge clk);
            end
            tests++;
            if (ms_n != 1 || ms_cyc != 1 || mrw_n != 5) begin
                fails++; $display("FAIL wr_strobe_h%0d: got %0d pulses at %0d mrw %0d cycles want 1 at 1, 5", h, ms_n, ms_cyc, mrw_n);
            end
            tests++;
            if (dr_cyc != 6) begin fails++; $display("FAIL wr_dready_h%0d: got %0d want 6", h, dr_cyc); end
            tests++;
            if (w_n != h || ws_bad != 0) begin
                fails++; $display("FAIL wr_w_h%0d: got %0d writes %0d bad wsel want %0d 0", h, w_n, ws_bad, h);
            end
            if (h == 1) begin
                tests++;
                if (w_cyc != 6) begin fails++; $display("FAIL wr_w_cycle: got %0d want 6", w_cyc); end
            end
        end
    endtask

    task automatic test_write_alloc();
        int wms_n = 0, rms_n = 0, rms_first = -1, fill_n = 0, sel_bad = 0, wd_n = 0, wd_cyc = -1, dr_cyc = -1, dr_n = 0;
        launch(1, 1'b1, 1'b0, 1'b0);
        for (int cyc = 0; cyc < 36; cyc++) begin
            if (ms1 === 1'b1 && mrw1 === 1'b1) wms_n++;
            if (ms1 === 1'b1 && mrw1 === 1'b0) begin rms_n++; if (rms_first < 0) rms_first = cyc; end
            if (w1 === 1'b1 && ws1 === 1'b1) begin
                if (wsel1 !== 2'(fill_n)) sel_bad++;
                fill_n++;
            end
            if (w1 === 1'b1 && ws1 === 1'b0) begin wd_n++; wd_cyc = cyc; end
            if (dr1 === 1'b1) begin dr_n++; dr_cyc = cyc; end
            @(negedge clk);
        end
        tests++;
        if (wms_n != 1 || rms_n != 4 || rms_first != 6) begin
            fails++; $display("FAIL wa_strobes: got wr %0d rd %0d first rd %0d want 1 4 6", wms_n, rms_n, rms_first);
        end
        tests++;
        if (fill_n != 4 || sel_bad != 0) begin
            fails++; $display("FAIL wa_fill: got %0d fills %0d bad want 4 0", fill_n, sel_bad);
        end
        tests++;
        if (wd_n != 1 || wd_cyc != 30 || dr_n != 1 || dr_cyc != 30) begin
            fails++; $display("FAIL wa_done: got w %0d@%0d dready %0d@%0d want 1@30 1@30", wd_n, wd_cyc, dr_n, dr_cyc);
        end
    endtask

    task automatic test_reset_mid();
        int dr_n = 0;
        launch(0, 1'b0, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        tests++;
        if (busy0 !== 1'b1) begin fails++; $display("FAIL mid_busy_before: got %b want 1", busy0); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++;
        if ({dr0, w0, ms0, mrw0, rs0, ws0, wsel0, busy0} !== 9'b0) begin
            fails++; $display("FAIL mid_reset_outputs: got %b want 0", {dr0, w0, ms0, mrw0, rs0, ws0, wsel0, busy0});
        end
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (dr0 === 1'b1 || busy0 === 1'b1) dr_n++;
        end
        tests++;
        if (dr_n != 0) begin fails++; $display("FAIL mid_abandoned: got %0d active cycles want 0", dr_n); end
        launch(0, 1'b0, 1'b1, 1'b1);
        tests++;
        if (dr0 !== 1'b1) begin fails++; $display("FAIL mid_hit_after: got %b want 1", dr0); end
        @(negedge clk);
    endtask

    task automatic test_small_line();
        int dr_cyc = -1, ws_bad = 0, w_n = 0, w_cyc = -1, ms_n = 0;
        logic busy_after = 1'b1;
        launch(2, 1'b0, 1'b0, 1'b0);
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (wsel2 !== 1'b0) ws_bad++;
            if (w2 === 1'b1) begin w_n++; w_cyc = cyc; end
            if (ms2 === 1'b1) ms_n++;
            if (dr2 === 1'b1 && dr_cyc < 0) dr_cyc = cyc;
            if (cyc == 5) busy_after = busy2;
            @(negedge clk);
        end
        tests++;
        if (dr_cyc != 4) begin fails++; $display("FAIL small_dready: got %0d want 4", dr_cyc); end
        tests++;
        if (ws_bad != 0) begin fails++; $display("FAIL small_wordsel: got %0d nonzero cycles want 0", ws_bad); end
        tests++;
        if (w_n != 1 || w_cyc != 3 || ms_n != 1 || busy_after !== 1'b0) begin
            fails++; $display("FAIL small_loop: got w %0d@%0d ms %0d busy %b want 1@3 1 0", w_n, w_cyc, ms_n, busy_after);
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_read_miss();
        test_write_hit();
        test_write_alloc();
        test_reset_mid();
        test_small_line();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
